ex_mem_wb_pipe: RTL and testbench

//  EX/MEM and MEM/WB pipeline registers plus the data-memory access engine of the 5-stage core.

---
 rtl/ex_mem_wb_pipe_pkg.sv | 5 +
 rtl/ex_mem_wb_pipe_dmem_access_fsm.sv | 39 +++
 rtl/ex_mem_wb_pipe.sv | 91 +++++++++
 tb/tb_ex_mem_wb_pipe.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_wb_pipe_pkg.sv
// ex_mem_wb_pipe_pkg: shared width default and dmem access FSM state encoding
package ex_mem_wb_pipe_pkg;
    localparam int DEF_DATA_W = 32;
    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} mem_state_e;
endpackage

// File: rtl/ex_mem_wb_pipe_dmem_access_fsm.sv
// dmem_access_fsm: dmem wait-state tracking with bounded wait, abort and sticky error flag
module dmem_access_fsm
    import ex_mem_wb_pipe_pkg::*;
#(
    parameter int WAIT_LIMIT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic mem_acc_i,
    input  logic ready_i,
    output logic abort_o,
    output logic err_o
);
    localparam int CW = $clog2(WAIT_LIMIT + 1);
    mem_state_e state;
    logic [CW-1:0] cnt;
    logic first_wait;
    assign first_wait = mem_acc_i && !ready_i;
    assign abort_o = (state == WAIT) && (cnt >= CW'(WAIT_LIMIT - 1)) && !ready_i;
    // cnt holds the number of cycles already spent waiting, so the stalled IDLE cycle counts as the first
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
            err_o <= 1'b0;
        end else begin
            if (abort_o) err_o <= 1'b1;
            if (state == IDLE) begin
                state <= first_wait ? WAIT : IDLE;
                cnt   <= first_wait ? CW'(1) : '0;
            end else if (ready_i || abort_o) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/ex_mem_wb_pipe.sv
// ex_mem_wb_pipe: EX/MEM and MEM/WB pipeline registers with stalling dmem access engine
module ex_mem_wb_pipe
    import ex_mem_wb_pipe_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int WAIT_LIMIT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ex_valid_i,
    input  logic              ex_RegWrite_i,
    input  logic              ex_MemtoReg_i,
    input  logic              ex_MemRead_i,
    input  logic              ex_MemWrite_i,
    input  logic [4:0]        ex_Rd_i,
    input  logic [DATA_W-1:0] ex_alu_i,
    input  logic [DATA_W-1:0] ex_store_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [DATA_W-1:0] dmem_addr_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    input  logic              dmem_ready_i,
    output logic              mem_stall_o,
    output logic              MEM_RegWrite_o,
    output logic [4:0]        MEM_Rd_o,
    output logic [DATA_W-1:0] MEM_alu_o,
    output logic              WB_RegWrite_o,
    output logic [4:0]        WB_Rd_o,
    output logic [DATA_W-1:0] WB_data_o,
    output logic              dmem_err_o
);
    logic              em_valid, em_regwrite, em_memtoreg, em_memread, em_memwrite;
    logic [4:0]        em_rd;
    logic [DATA_W-1:0] em_alu, em_store;
    logic              wb_valid, wb_regwrite, wb_memtoreg;
    logic [4:0]        wb_rd;
    logic [DATA_W-1:0] wb_alu, wb_load;
    logic              mem_acc, abort;

    assign mem_acc        = em_valid && (em_memread || em_memwrite);
    assign mem_stall_o    = mem_acc && !dmem_ready_i && !abort;
    assign dmem_req_o     = mem_acc;
    assign dmem_we_o      = mem_acc && em_memwrite;
    assign dmem_addr_o    = em_alu;
    assign dmem_wdata_o   = em_store;
    assign MEM_RegWrite_o = em_valid && em_regwrite;
    assign MEM_Rd_o       = em_rd;
    assign MEM_alu_o      = em_alu;
    assign WB_RegWrite_o  = wb_valid && wb_regwrite;
    assign WB_Rd_o        = wb_rd;
    assign WB_data_o      = wb_memtoreg ? wb_load : wb_alu;

    dmem_access_fsm #(.WAIT_LIMIT(WAIT_LIMIT)) u_fsm (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .mem_acc_i(mem_acc),
        .ready_i  (dmem_ready_i),
        .abort_o  (abort),
        .err_o    (dmem_err_o)
    );

    // both stages freeze together so the WB forward path stays valid for the held EX instruction
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            {em_valid, em_regwrite, em_memtoreg, em_memread, em_memwrite} <= '0;
            em_rd    <= '0;
            em_alu   <= '0;
            em_store <= '0;
            {wb_valid, wb_regwrite, wb_memtoreg} <= '0;
            wb_rd    <= '0;
            wb_alu   <= '0;
            wb_load  <= '0;
        end else if (!mem_stall_o) begin
            em_valid    <= ex_valid_i;
            em_regwrite <= ex_RegWrite_i;
            em_memtoreg <= ex_MemtoReg_i;
            em_memread  <= ex_MemRead_i;
            em_memwrite <= ex_MemWrite_i;
            em_rd       <= ex_Rd_i;
            em_alu      <= ex_alu_i;
            em_store    <= ex_store_i;
            wb_valid    <= em_valid;
            wb_regwrite <= em_regwrite;
            wb_memtoreg <= em_memtoreg;
            wb_rd       <= em_rd;
            wb_alu      <= em_alu;
            wb_load     <= (mem_acc && dmem_ready_i) ? dmem_rdata_i : '0;
        end
    end
endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// tb_ex_mem_wb_pipe: directed scenario checks for the EX/MEM/WB pipeline and dmem engine
module tb_ex_mem_wb_pipe;
    logic        clk = 1'b0, rst = 1'b1;
    logic        ex_valid, ex_regwrite, ex_memtoreg, ex_memread, ex_memwrite;
    logic [4:0]  ex_rd;
    logic [31:0] ex_alu, ex_store;
    logic        dmem_req, dmem_we, dmem_ready, mem_stall, mem_regwrite, wb_regwrite, dmem_err;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, mem_alu, wb_data;
    logic [4:0]  mem_rd, wb_rd;
    logic [143:0] all_outs;
    int passed = 0, total = 0;

    assign all_outs = {dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_stall, mem_regwrite, mem_rd,
                       mem_alu, wb_regwrite, wb_rd, wb_data, dmem_err};

    always #5 clk = ~clk;

    ex_mem_wb_pipe #(.DATA_W(32), .WAIT_LIMIT(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .ex_valid_i(ex_valid), .ex_RegWrite_i(ex_regwrite), .ex_MemtoReg_i(ex_memtoreg),
        .ex_MemRead_i(ex_memread), .ex_MemWrite_i(ex_memwrite), .ex_Rd_i(ex_rd),
        .ex_alu_i(ex_alu), .ex_store_i(ex_store),
        .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr),
        .dmem_wdata_o(dmem_wdata), .dmem_rdata_i(dmem_rdata), .dmem_ready_i(dmem_ready),
        .mem_stall_o(mem_stall), .MEM_RegWrite_o(mem_regwrite), .MEM_Rd_o(mem_rd),
        .MEM_alu_o(mem_alu), .WB_RegWrite_o(wb_regwrite), .WB_Rd_o(wb_rd),
        .WB_data_o(wb_data), .dmem_err_o(dmem_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, rw, m2r, mr, mw, input logic [4:0] rd,
                         input logic [31:0] alu, st);
        {ex_valid, ex_regwrite, ex_memtoreg, ex_memread, ex_memwrite} = {v, rw, m2r, mr, mw};
        ex_rd = rd;
        ex_alu = alu;
        ex_store = st;
    endtask

    task automatic bubble;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        total++; if (all_outs !== '0) $display("FAIL reset_outs got %h want 0", all_outs); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_back_to_back;
        drive(1, 1, 0, 0, 0, 5'd1, 32'h11, 32'h0);
        tick;
        total++; if (mem_rd !== 5'd1 || mem_regwrite !== 1'b1 || mem_alu !== 32'h11)
            $display("FAIL b2b_mem1 got rd=%0d rw=%b alu=%h want 1 1 11", mem_rd, mem_regwrite, mem_alu); else passed++;
        drive(1, 1, 0, 0, 0, 5'd2, 32'h22, 32'h0);
        tick;
        total++; if (mem_rd !== 5'd2) $display("FAIL b2b_mem2 got %0d want 2", mem_rd); else passed++;
        total++; if (wb_rd !== 5'd1 || wb_data !== 32'h11 || wb_regwrite !== 1'b1)
            $display("FAIL b2b_wb1 got rd=%0d data=%h want 1 11", wb_rd, wb_data); else passed++;
        drive(1, 1, 0, 0, 0, 5'd3, 32'h33, 32'h0);
        tick;
        total++; if (mem_rd !== 5'd3 || wb_rd !== 5'd2) $display("FAIL b2b_mem3 got mem=%0d wb=%0d want 3 2", mem_rd, wb_rd); else passed++;
        total++; if (mem_stall !== 1'b0 || dmem_req !== 1'b0) $display("FAIL b2b_nostall got stall=%b req=%b want 0 0", mem_stall, dmem_req); else passed++;
        bubble;
        tick;
        total++; if (wb_rd !== 5'd3 || wb_data !== 32'h33) $display("FAIL b2b_wb3 got rd=%0d data=%h want 3 33", wb_rd, wb_data); else passed++;
        total++; if (mem_regwrite !== 1'b0) $display("FAIL b2b_bubble_rw got %b want 0", mem_regwrite); else passed++;
    endtask

    task automatic test_lw_zero_wait;
        drive(1, 1, 1, 1, 0, 5'd5, 32'h100, 32'h0);
        tick;
        bubble;
        dmem_ready = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        #1;
        total++; if (mem_stall !== 1'b0) $display("FAIL lw0_stall got %b want 0", mem_stall); else passed++;
        total++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h100)
            $display("FAIL lw0_req got req=%b we=%b addr=%h want 1 0 100", dmem_req, dmem_we, dmem_addr); else passed++;
        tick;
        dmem_ready = 1'b0;
        total++; if (wb_rd !== 5'd5 || wb_data !== 32'hDEADBEEF || wb_regwrite !== 1'b1)
            $display("FAIL lw0_wb got rd=%0d data=%h rw=%b want 5 deadbeef 1", wb_rd, wb_data, wb_regwrite); else passed++;
    endtask

    task automatic test_lw_wait3;
        drive(1, 1, 0, 0, 0, 5'd7, 32'h77, 32'h0);
        tick;
        drive(1, 1, 1, 1, 0, 5'd6, 32'h200, 32'h0);
        tick;
        drive(1, 1, 0, 0, 0, 5'd8, 32'h88, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (mem_stall !== 1'b1) $display("FAIL lw3_stall%0d got %b want 1", i, mem_stall); else passed++;
            total++; if (wb_rd !== 5'd7 || wb_data !== 32'h77) $display("FAIL lw3_hold%0d got rd=%0d data=%h want 7 77", i, wb_rd, wb_data); else passed++;
            tick;
        end
        dmem_ready = 1'b1;
        dmem_rdata = 32'hCAFEF00D;
        #1;
        total++; if (mem_stall !== 1'b0) $display("FAIL lw3_release got %b want 0", mem_stall); else passed++;
        tick;
        dmem_ready = 1'b0;
        total++; if (wb_rd !== 5'd6 || wb_data !== 32'hCAFEF00D)
            $display("FAIL lw3_wb got rd=%0d data=%h want 6 cafef00d", wb_rd, wb_data); else passed++;
        total++; if (mem_rd !== 5'd8 || dmem_err !== 1'b0) $display("FAIL lw3_next got rd=%0d err=%b want 8 0", mem_rd, dmem_err); else passed++;
        bubble;
        tick;
    endtask

    task automatic test_sw_abort;
        drive(1, 0, 0, 0, 1, 5'd0, 32'h300, 32'h55);
        tick;
        bubble;
        total++; if (dmem_we !== 1'b1 || dmem_wdata !== 32'h55 || dmem_addr !== 32'h300)
            $display("FAIL sw_bus got we=%b wdata=%h addr=%h want 1 55 300", dmem_we, dmem_wdata, dmem_addr); else passed++;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (dmem_req !== 1'b1) $display("FAIL sw_req%0d got %b want 1", i, dmem_req); else passed++;
            total++; if (mem_stall !== (i < 3)) $display("FAIL sw_stall%0d got %b want %b", i, mem_stall, i < 3); else passed++;
            total++; if (dmem_err !== 1'b0) $display("FAIL sw_err_early%0d got %b want 0", i, dmem_err); else passed++;
            tick;
        end
        total++; if (dmem_err !== 1'b1 || dmem_req !== 1'b0) $display("FAIL sw_abort got err=%b req=%b want 1 0", dmem_err, dmem_req); else passed++;
    endtask

    task automatic test_both_bits;
        drive(1, 0, 0, 1, 1, 5'd0, 32'h500, 32'h66);
        tick;
        total++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) $display("FAIL both_we got req=%b we=%b want 1 1", dmem_req, dmem_we); else passed++;
        dmem_ready = 1'b1;
        bubble;
        tick;
        dmem_ready = 1'b0;
    endtask

    task automatic test_reset_in_wait;
        drive(1, 1, 1, 1, 0, 5'd9, 32'h600, 32'h0);
        tick;
        bubble;
        tick;
        total++; if (mem_stall !== 1'b1 || dmem_err !== 1'b1) $display("FAIL rstw_pre got stall=%b err=%b want 1 1", mem_stall, dmem_err); else passed++;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        total++; if (all_outs !== '0) $display("FAIL rstw_outs got %h want 0", all_outs); else passed++;
    endtask

    task automatic test_bubble;
        drive(1, 1, 1, 1, 0, 5'd10, 32'h400, 32'h0);
        tick;
        bubble;
        dmem_ready = 1'b1;
        dmem_rdata = 32'h1234;
        tick;
        total++; if (wb_rd !== 5'd10 || wb_data !== 32'h1234) $display("FAIL bub_lw got rd=%0d data=%h want 10 1234", wb_rd, wb_data); else passed++;
        total++; if (mem_regwrite !== 1'b0 || dmem_req !== 1'b0) $display("FAIL bub_slot got rw=%b req=%b want 0 0", mem_regwrite, dmem_req); else passed++;
        dmem_rdata = 32'hBAD;
        drive(1, 1, 0, 0, 0, 5'd11, 32'hAB, 32'h0);
        #1;
        total++; if (mem_stall !== 1'b0) $display("FAIL bub_stall got %b want 0", mem_stall); else passed++;
        tick;
        dmem_ready = 1'b0;
        total++; if (wb_regwrite !== 1'b0 || mem_rd !== 5'd11 || mem_regwrite !== 1'b1)
            $display("FAIL bub_wb got wbrw=%b memrd=%0d memrw=%b want 0 11 1", wb_regwrite, mem_rd, mem_regwrite); else passed++;
        bubble;
        tick;
        total++; if (wb_rd !== 5'd11 || wb_data !== 32'hAB || dmem_err !== 1'b0)
            $display("FAIL bub_add got rd=%0d data=%h err=%b want 11 ab 0", wb_rd, wb_data, dmem_err); else passed++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "timeout");
    end

    initial begin
        bubble;
        dmem_ready = 1'b0;
        dmem_rdata = 32'h0;
        #1;
        test_reset;
        test_back_to_back;
        test_lw_zero_wait;
        test_lw_wait3;
        test_sw_abort;
        test_both_bits;
        test_reset_in_wait;
        test_bubble;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
